// File: rtl/tspi_ctrl.sv
// tspi_ctrl: transfer sequencer for the ternary serial link.
// Shifts a TRITS-trit word out MSB-trit first on O_mosi and captures the
// same number of trits from I_miso. The select and shift clock on O_sck
// are generated here from a CLKDIV-cycle half-period divider.
// Each 2-bit trit is coded 00 = 0, 01 = +1, 10 = -1, 11 = invalid.
// Optional build macro TSPI_CHECK_EN: an invalid captured trit is stored
// as 00 and raises the sticky O_err flag. Without the macro, captured
// trits are stored raw and O_err is tied low.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for I_start; outputs quiet
// SETUP  | select asserted, first trit presented, clock low
// HIGH   | shift clock high; I_miso was captured on entry
// LOW    | shift clock low; next trit presented (last trit held)
// DONE   | one-cycle completion pulse, then back to IDLE
module tspi_ctrl #(
    parameter int TRITS  = 3,
    parameter int CLKDIV = 1
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic [2*TRITS-1:0] I_tx_data,
    output logic               O_busy,
    output logic               O_done,
    output logic [2*TRITS-1:0] O_rx_data,
    output logic [1:0]         O_mosi,
    input  logic [1:0]         I_miso,
    output logic [1:0]         O_sck,
    output logic               O_err
);

    localparam int W     = 2 * TRITS;
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CNT_W = (TRITS > 0) ? $clog2(TRITS + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(TRITS);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     tx_q, tx_d;
    logic [W-1:0]     rx_q, rx_d;

    logic             phase_end;
    logic             capture;
    logic             start_clr;
    logic [1:0]       cap_trit;

    assign phase_end = (div_q == DIV_LAST);

`ifdef TSPI_CHECK_EN
    logic err_q, err_d;
    logic miso_bad;

    assign miso_bad = (I_miso == 2'b11);
    assign cap_trit = miso_bad ? 2'b00 : I_miso;

    // Sticky invalid-trit flag, cleared when a new transfer is accepted.
    always_comb begin
        err_d = err_q;
        if (start_clr) begin
            err_d = 1'b0;
        end else if (capture && miso_bad) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign O_err = err_q;
`else
    assign cap_trit = I_miso;
    assign O_err    = 1'b0;
`endif

    // Sequencer state, divider, trit counter and shift registers.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    // Next-state logic; capture happens on every edge that enters HIGH.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        capture   = 1'b0;
        start_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (I_start) begin
                    start_clr = 1'b1;
                    tx_d      = I_tx_data;
                    rx_d      = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    div_d   = '0;
                    capture = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    div_d   = '0;
                    state_d = ST_LOW;
                    // The final LOW keeps the last trit on the lane.
                    if (cnt_q != CNT_FINAL) begin
                        tx_d = tx_q << 2;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    div_d = '0;
                    if (cnt_q == CNT_FINAL) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        capture = 1'b1;
                        state_d = ST_HIGH;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DONE: begin
                div_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            rx_d = W'({rx_q, cap_trit});
        end
    end

    // Link and handshake outputs decoded from the current state.
    always_comb begin
        O_busy = 1'b1;
        O_done = 1'b0;
        O_sck  = 2'b00;
        O_mosi = 2'b00;
        case (state_q)
            ST_IDLE: begin
                O_busy = 1'b0;
            end
            ST_SETUP, ST_LOW: begin
                O_sck  = 2'b10;
                O_mosi = tx_q[W-1 -: 2];
            end
            ST_HIGH: begin
                O_sck  = 2'b11;
                O_mosi = tx_q[W-1 -: 2];
            end
            ST_DONE: begin
                O_done = 1'b1;
            end
            default: begin
                O_busy = 1'b0;
            end
        endcase
    end

    assign O_rx_data = rx_q;

endmodule

// File: tb/tb_tspi_ctrl.sv
// Directed bench for tspi_ctrl: one instance with TRITS=3/CLKDIV=1 and one
// with TRITS=2/CLKDIV=3. Cycle numbers count the cycle right after the
// accepting edge as cycle 1, so the done pulse appears at cycle
// CLKDIV*(2*TRITS+1)+1.
module tb_tspi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start_a;
    logic [5:0] tx_a;
    logic       busy_a, done_a, err_a;
    logic [5:0] rx_a;
    logic [1:0] mosi_a, miso_a, sck_a;

    logic       start_b;
    logic [3:0] tx_b;
    logic       busy_b, done_b, err_b;
    logic [3:0] rx_b;
    logic [1:0] mosi_b, miso_b, sck_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tspi_ctrl #(.TRITS(3), .CLKDIV(1)) dut_a (
        .I_clk(clk), .I_rst(rst_n), .I_start(start_a), .I_tx_data(tx_a),
        .O_busy(busy_a), .O_done(done_a), .O_rx_data(rx_a), .O_mosi(mosi_a),
        .I_miso(miso_a), .O_sck(sck_a), .O_err(err_a)
    );

    tspi_ctrl #(.TRITS(2), .CLKDIV(3)) dut_b (
        .I_clk(clk), .I_rst(rst_n), .I_start(start_b), .I_tx_data(tx_b),
        .O_busy(busy_b), .O_done(done_b), .O_rx_data(rx_b), .O_mosi(mosi_b),
        .I_miso(miso_b), .O_sck(sck_b), .O_err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follows one transfer of dut_a from cycle 1 until the done pulse.
    // Drives I_miso trit by trit (MSB first) during SETUP/LOW and records
    // the trit presented on each HIGH. With spam set, I_start stays high
    // and I_tx_data is scrambled every cycle.
    task automatic watch_a(input bit spam, input logic [5:0] miso_seq,
                           output int done_cyc, output logic [5:0] mosi_seq);
        int c;
        int hi;
        logic [1:0] prev;
        c        = 1;
        hi       = 0;
        prev     = 2'b00;
        done_cyc = -1;
        mosi_seq = '0;
        if (!spam) start_a = 1'b0;
        while (c <= 40) begin
            if (done_a) begin
                done_cyc = c;
                break;
            end
            if (sck_a == 2'b11 && prev != 2'b11) begin
                mosi_seq = {mosi_seq[3:0], mosi_a};
                hi++;
            end
            prev = sck_a;
            if (sck_a == 2'b10) miso_a = (hi < 3) ? miso_seq[5-2*hi -: 2] : 2'b00;
            if (spam) tx_a = 6'($urandom);
            step();
            c++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dc;
        logic [5:0] ms;
        int         hi;
        logic [1:0] prev;
        bit         seen_done;
        int         runs[$];
        int         run;
        int         dcb;
        logic [3:0] msb;

        rst_n   = 1'b0;
        start_a = 1'b0; tx_a = '0; miso_a = '0;
        start_b = 1'b0; tx_b = '0; miso_b = '0;

        // 1: reset state, then a basic transfer
        repeat (10) step();
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_done", done_a, 1'b0);
        check_eq("rst_rx",   rx_a,   6'b0);
        check_eq("rst_mosi", mosi_a, 2'b00);
        check_eq("rst_sck",  sck_a,  2'b00);
        check_eq("rst_err",  err_a,  1'b0);
        check_eq("rst_b",    {busy_b, done_b, rx_b, mosi_b, sck_b, err_b}, 11'b0);
        rst_n = 1'b1;
        step();
        start_a = 1'b1; tx_a = 6'b000010; miso_a = 2'b01;
        step();
        check_eq("t1_busy",  busy_a, 1'b1);
        check_eq("t1_setup", {sck_a, mosi_a}, 4'b1000);
        watch_a(1'b0, 6'b010101, dc, ms);
        check_eq("t1_done_cyc", dc, 8);
        check_eq("t1_mosi",     ms, 6'b000010);
        check_eq("t1_rx",       rx_a, 6'b010101);
        check_eq("t1_done_sck", {busy_a, sck_a, mosi_a}, 5'b10000);
        step();
        check_eq("t1_pulse", {done_a, busy_a}, 2'b00);
        repeat (3) step();
        check_eq("t1_rx_hold", rx_a, 6'b010101);

        // 2: start held high throughout, tx scrambled after acceptance
        start_a = 1'b1; tx_a = 6'b011000;
        step();
        watch_a(1'b1, 6'b100001, dc, ms);
        check_eq("t2_done_cyc", dc, 8);
        check_eq("t2_mosi",     ms, 6'b011000);
        check_eq("t2_rx",       rx_a, 6'b100001);
        tx_a = 6'b100110;
        step();
        check_eq("t2_idle", {done_a, busy_a}, 2'b00);
        step();
        check_eq("t2_b2b", {busy_a, sck_a}, 3'b110);
        check_eq("t2_rx_clr", rx_a, 6'b0);
        watch_a(1'b0, 6'b011001, dc, ms);
        check_eq("t2b_done_cyc", dc, 8);
        check_eq("t2b_mosi",     ms, 6'b100110);
        check_eq("t2b_rx",       rx_a, 6'b011001);
        step();

        // 3: reset during the second HIGH aborts the transfer
        start_a = 1'b1; tx_a = 6'b010101; miso_a = 2'b01;
        step();
        start_a = 1'b0;
        hi = 0; prev = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (sck_a == 2'b11 && prev != 2'b11) hi++;
            if (hi == 2) break;
            prev = sck_a;
            step();
        end
        check_eq("t3_in_high2", {hi[1:0], sck_a}, 4'b1011);
        rst_n = 1'b0;
        #1;
        check_eq("t3_abort", {busy_a, done_a, sck_a, mosi_a, err_a}, 7'b0);
        check_eq("t3_rx",    rx_a, 6'b0);
        seen_done = 1'b0;
        repeat (3) begin
            step();
            seen_done = seen_done | done_a;
        end
        check_eq("t3_no_done", seen_done, 1'b0);
        rst_n = 1'b1;
        step();
        start_a = 1'b1; tx_a = 6'b101000;
        step();
        watch_a(1'b0, 6'b000110, dc, ms);
        check_eq("t3_done_cyc", dc, 8);
        check_eq("t3_mosi",     ms, 6'b101000);
        check_eq("t3_rx",       rx_a, 6'b000110);
        step();

        // 4: TRITS=2, CLKDIV=3 half periods and latency
        start_b = 1'b1; tx_b = 4'b0110; miso_b = 2'b10;
        step();
        start_b = 1'b0;
        dcb = -1; msb = '0; run = 0; prev = sck_b;
        for (int c = 1; c <= 60; c++) begin
            if (done_b) begin
                runs.push_back(run);
                dcb = c;
                break;
            end
            if (sck_b != prev) begin
                runs.push_back(run);
                run = 1;
                if (sck_b == 2'b11) msb = {msb[1:0], mosi_b};
                prev = sck_b;
            end else begin
                run++;
            end
            step();
        end
        check_eq("t4_done_cyc", dcb, 16);
        check_eq("t4_runs", runs.size(), 5);
        for (int i = 0; i < runs.size(); i++) check_eq("t4_half", runs[i], 3);
        check_eq("t4_mosi", msb, 4'b0110);
        check_eq("t4_rx",   rx_b, 4'b1010);

        // 5: invalid trit on trit 1, invalid trit on tx passes unmodified
        start_a = 1'b1; tx_a = 6'b110001;
        step();
        watch_a(1'b0, 6'b011110, dc, ms);
        check_eq("t5_done_cyc", dc, 8);
        check_eq("t5_mosi",     ms, 6'b110001);
`ifdef TSPI_CHECK_EN
        check_eq("t5_rx",  rx_a, 6'b010010);
        check_eq("t5_err", err_a, 1'b1);
        repeat (2) step();
        check_eq("t5_err_sticky", err_a, 1'b1);
`else
        check_eq("t5_rx",  rx_a, 6'b011110);
        check_eq("t5_err", err_a, 1'b0);
        repeat (2) step();
        check_eq("t5_err_sticky", err_a, 1'b0);
`endif
        start_a = 1'b1; tx_a = 6'b000000;
        step();
        check_eq("t5_err_clr", err_a, 1'b0);
        watch_a(1'b0, 6'b000000, dc, ms);
        check_eq("t5b_err", err_a, 1'b0);
        check_eq("t5b_rx",  rx_a, 6'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
